// File: rtl/radix_alu_responder_if.sv
// Compute handshake bundle between the benchmark sequencer (master) and
// one radix ALU responder (slave).
interface radix_alu_responder_if;
  logic        compute_enable;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic [3:0]  operation;
  logic [15:0] result;
  logic [19:0] result_digits;
  logic        result_valid;
  logic        error;
  logic        busy;

  modport master (
    output compute_enable, operand_a, operand_b, operation,
    input  result, result_digits, result_valid, error, busy
  );

  modport slave (
    input  compute_enable, operand_a, operand_b, operation,
    output result, result_digits, result_valid, error, busy
  );
endinterface

// File: rtl/radix_alu_responder.sv
// Radix ALU responder: nine-op ALU with iterative MUL/DIV/shift, followed
// by an optional binary-to-radix digit conversion (RADIX 10 or 12).
// Outputs are committed only when the result becomes valid, so an aborted
// request leaves the previous result and digits untouched.
module radix_alu_responder #(
  parameter int RADIX = 2
) (
  input logic                  clk,
  input logic                  reset,
  radix_alu_responder_if.slave bus
);

  localparam int          RADIX_EFF = (RADIX == 10 || RADIX == 12) ? RADIX : 2;
  localparam bit          CONV_EN   = (RADIX_EFF != 2) ? 1'b1 : 1'b0;
  localparam logic [15:0] RADIX_W   = 16'(RADIX_EFF);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    CONVERT = 2'd2,
    VALID   = 2'd3
  } state_t;

  // Number of EXEC cycles an operation needs, decided from the start-time operands.
  function automatic logic [4:0] exec_len(input logic [3:0] op, input logic [15:0] b);
    logic [4:0] len;
    len = 5'd1;
    case (op)
      OP_MUL:         len = 5'd16;
      OP_DIV:         len = (b == 16'd0) ? 5'd1 : 5'd16;
      OP_SHL, OP_SHR: len = ((b >= 16'd16) || (b[3:0] == 4'd0)) ? 5'd1 : {1'b0, b[3:0]};
      default:        len = 5'd1;
    endcase
    return len;
  endfunction

  state_t      state_r, state_nxt_s;
  logic [15:0] a_r, b_r, acc_r, rem_r;
  logic [3:0]  op_r;
  logic [4:0]  cnt_r;
  logic [15:0] res_work_r, conv_val_r;
  logic        err_work_r;
  logic [19:0] dig_work_r;
  logic [2:0]  dig_cnt_r;
  logic [15:0] result_r;
  logic [19:0] digits_r;
  logic        valid_r, error_r, busy_r;

  logic [15:0] a_nxt_s, b_nxt_s, acc_nxt_s, rem_nxt_s, exec_res_s;
  logic        exec_err_s;
  logic [16:0] div_sh_s, div_diff_s;
  logic        div_q_s;
  logic [3:0]  digit_s;
  logic [15:0] conv_quot_s;
  logic [19:0] dig_fill_s;
  logic        busy_nxt_s, valid_nxt_s, start_s, commit_s;
  logic [15:0] commit_res_s;
  logic [19:0] commit_dig_s;
  logic        commit_err_s;

  assign bus.result        = result_r;
  assign bus.result_digits = digits_r;
  assign bus.result_valid  = valid_r;
  assign bus.error         = error_r;
  assign bus.busy          = busy_r;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next-state decode; a dropped request level aborts EXEC/CONVERT.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.compute_enable) state_nxt_s = EXEC;
        else                    state_nxt_s = IDLE;
      end
      EXEC: begin
        if (!bus.compute_enable) state_nxt_s = IDLE;
        else if (cnt_r == 5'd0) begin
          if (CONV_EN) state_nxt_s = CONVERT;
          else         state_nxt_s = VALID;
        end else       state_nxt_s = EXEC;
      end
      CONVERT: begin
        if (!bus.compute_enable)    state_nxt_s = IDLE;
        else if (dig_cnt_r == 3'd4) state_nxt_s = VALID;
        else                        state_nxt_s = CONVERT;
      end
      VALID: begin
        if (!bus.compute_enable) state_nxt_s = IDLE;
        else                     state_nxt_s = VALID;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // One ALU step per EXEC cycle: shift-add multiply, restoring divide, 1-bit shifts.
  always_comb begin
    a_nxt_s    = a_r;
    b_nxt_s    = b_r;
    acc_nxt_s  = acc_r;
    rem_nxt_s  = rem_r;
    exec_res_s = 16'd0;
    exec_err_s = 1'b0;
    div_sh_s   = {rem_r, a_r[15]};
    div_diff_s = div_sh_s - {1'b0, b_r};
    div_q_s    = (div_sh_s >= {1'b0, b_r});
    case (op_r)
      OP_ADD: exec_res_s = a_r + b_r;
      OP_SUB: exec_res_s = a_r - b_r;
      OP_MUL: begin
        acc_nxt_s  = acc_r + (b_r[0] ? a_r : 16'd0);
        a_nxt_s    = {a_r[14:0], 1'b0};
        b_nxt_s    = {1'b0, b_r[15:1]};
        exec_res_s = acc_nxt_s;
      end
      OP_DIV: begin
        if (b_r == 16'd0) begin
          exec_res_s = 16'hFFFF;
          exec_err_s = 1'b1;
        end else begin
          a_nxt_s    = {a_r[14:0], div_q_s};
          rem_nxt_s  = div_q_s ? div_diff_s[15:0] : div_sh_s[15:0];
          exec_res_s = a_nxt_s;
        end
      end
      OP_AND: exec_res_s = a_r & b_r;
      OP_OR:  exec_res_s = a_r | b_r;
      OP_XOR: exec_res_s = a_r ^ b_r;
      OP_SHL: begin
        if (b_r >= 16'd16) exec_res_s = 16'd0;
        else if (b_r[3:0] != 4'd0) begin
          a_nxt_s    = {a_r[14:0], 1'b0};
          exec_res_s = a_nxt_s;
        end else exec_res_s = a_r;
      end
      OP_SHR: begin
        if (b_r >= 16'd16) exec_res_s = 16'd0;
        else if (b_r[3:0] != 4'd0) begin
          a_nxt_s    = {1'b0, a_r[15:1]};
          exec_res_s = a_nxt_s;
        end else exec_res_s = a_r;
      end
      default: begin
        exec_res_s = 16'd0;
        exec_err_s = 1'b1;
      end
    endcase
  end

  // One radix digit per CONVERT cycle, placed at the slot given by the digit counter.
  always_comb begin
    digit_s     = 4'(conv_val_r % RADIX_W);
    conv_quot_s = conv_val_r / RADIX_W;
    dig_fill_s  = dig_work_r;
    dig_fill_s[{dig_cnt_r, 2'b00} +: 4] = digit_s;
  end

  // Output decode: next busy/valid levels and the values committed on entering VALID.
  always_comb begin
    busy_nxt_s  = (state_nxt_s == EXEC) || (state_nxt_s == CONVERT);
    valid_nxt_s = (state_nxt_s == VALID);
    start_s     = (state_r == IDLE) && bus.compute_enable;
    commit_s    = (state_nxt_s == VALID) && (state_r != VALID);
    case (state_r)
      EXEC: begin
        commit_res_s = exec_res_s;
        commit_dig_s = {4'h0, exec_res_s};
        commit_err_s = exec_err_s;
      end
      CONVERT: begin
        commit_res_s = res_work_r;
        commit_dig_s = dig_fill_s;
        commit_err_s = err_work_r;
      end
      default: begin
        commit_res_s = result_r;
        commit_dig_s = digits_r;
        commit_err_s = error_r;
      end
    endcase
  end

  // Working datapath: operand latch at start, iteration in EXEC, digit extraction in CONVERT.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r        <= 16'd0;
      b_r        <= 16'd0;
      acc_r      <= 16'd0;
      rem_r      <= 16'd0;
      op_r       <= 4'd0;
      cnt_r      <= 5'd0;
      res_work_r <= 16'd0;
      err_work_r <= 1'b0;
      conv_val_r <= 16'd0;
      dig_work_r <= 20'd0;
      dig_cnt_r  <= 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.compute_enable) begin
            a_r   <= bus.operand_a;
            b_r   <= bus.operand_b;
            op_r  <= bus.operation;
            acc_r <= 16'd0;
            rem_r <= 16'd0;
            cnt_r <= exec_len(bus.operation, bus.operand_b) - 5'd1;
          end
        end
        EXEC: begin
          a_r   <= a_nxt_s;
          b_r   <= b_nxt_s;
          acc_r <= acc_nxt_s;
          rem_r <= rem_nxt_s;
          if (cnt_r != 5'd0) cnt_r <= cnt_r - 5'd1;
          else begin
            res_work_r <= exec_res_s;
            err_work_r <= exec_err_s;
            conv_val_r <= exec_res_s;
            dig_work_r <= 20'd0;
            dig_cnt_r  <= 3'd0;
          end
        end
        CONVERT: begin
          conv_val_r <= conv_quot_s;
          dig_work_r <= dig_fill_s;
          dig_cnt_r  <= dig_cnt_r + 3'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Registered outputs: busy/valid follow the next state, results change only on commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_r <= 16'd0;
      digits_r <= 20'd0;
      valid_r  <= 1'b0;
      error_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      busy_r  <= busy_nxt_s;
      valid_r <= valid_nxt_s;
      if (start_s) error_r <= 1'b0;
      else if (commit_s) begin
        result_r <= commit_res_s;
        digits_r <= commit_dig_s;
        error_r  <= commit_err_s;
      end
    end
  end

endmodule

// File: tb/tb_radix_alu_responder.sv
// Self-checking bench: three responders (RADIX 2, 10, 12) share one request
// stream; results, digits, error and latency are compared to an arithmetic model.
module tb_radix_alu_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] a, b;
  logic [3:0]  op;

  always #5 clk = ~clk;

  radix_alu_responder_if bus2 ();
  radix_alu_responder_if bus10 ();
  radix_alu_responder_if bus12 ();

  assign bus2.compute_enable  = en;
  assign bus2.operand_a       = a;
  assign bus2.operand_b       = b;
  assign bus2.operation       = op;
  assign bus10.compute_enable = en;
  assign bus10.operand_a      = a;
  assign bus10.operand_b      = b;
  assign bus10.operation      = op;
  assign bus12.compute_enable = en;
  assign bus12.operand_a      = a;
  assign bus12.operand_b      = b;
  assign bus12.operation      = op;

  radix_alu_responder #(.RADIX(2))  dut2  (.clk(clk), .reset(reset), .bus(bus2));
  radix_alu_responder #(.RADIX(10)) dut10 (.clk(clk), .reset(reset), .bus(bus10));
  radix_alu_responder #(.RADIX(12)) dut12 (.clk(clk), .reset(reset), .bus(bus12));

  logic [2:0]  o_valid, o_busy, o_err;
  logic [15:0] o_res [3];
  logic [19:0] o_dig [3];

  assign o_valid  = {bus12.result_valid, bus10.result_valid, bus2.result_valid};
  assign o_busy   = {bus12.busy, bus10.busy, bus2.busy};
  assign o_err    = {bus12.error, bus10.error, bus2.error};
  assign o_res[0] = bus2.result;
  assign o_res[1] = bus10.result;
  assign o_res[2] = bus12.result;
  assign o_dig[0] = bus2.result_digits;
  assign o_dig[1] = bus10.result_digits;
  assign o_dig[2] = bus12.result_digits;

  int          tests = 0;
  int          fails = 0;
  int          radix_of [3] = '{2, 10, 12};
  logic [15:0] prev_res [3];
  logic [19:0] prev_dig [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  // Reference: plain arithmetic on the operation rules, plus the EXEC cycle count.
  task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic [3:0] mop,
                       output logic [15:0] res, output logic err, output int n);
    int unsigned ai, bi;
    ai = ma; bi = mb; err = 1'b0; n = 1;
    case (mop)
      4'd0: res = 16'(ai + bi);
      4'd1: res = 16'(ai - bi);
      4'd2: begin res = 16'(ai * bi); n = 16; end
      4'd3: begin
        if (bi == 0) begin res = 16'hFFFF; err = 1'b1; end
        else begin res = 16'(ai / bi); n = 16; end
      end
      4'd4: res = ma & mb;
      4'd5: res = ma | mb;
      4'd6: res = ma ^ mb;
      4'd7, 4'd8: begin
        if (bi >= 16) res = 16'd0;
        else begin
          res = (mop == 4'd7) ? 16'(ai << bi) : 16'(ai >> bi);
          n = (bi == 0) ? 1 : int'(bi);
        end
      end
      default: begin res = 16'd0; err = 1'b1; end
    endcase
  endtask

  function automatic logic [19:0] model_digits(input logic [15:0] v, input int r);
    logic [19:0] d;
    int unsigned x;
    if (r == 2) return {4'h0, v};
    d = 20'd0; x = v;
    for (int i = 0; i < 5; i++) begin
      d[i*4 +: 4] = 4'(x % r);
      x = x / r;
    end
    return d;
  endfunction

  task automatic check_idle_outputs(input string name);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s r%0d valid", name, radix_of[i]), 32'(o_valid[i]), 32'd0);
      check($sformatf("%s r%0d busy", name, radix_of[i]), 32'(o_busy[i]), 32'd0);
      check($sformatf("%s r%0d result", name, radix_of[i]), 32'(o_res[i]), 32'(prev_res[i]));
      check($sformatf("%s r%0d digits", name, radix_of[i]), 32'(o_dig[i]), 32'(prev_dig[i]));
    end
  endtask

  // One full request: start, scramble inputs while busy, wait for valid on all three,
  // hold enable in VALID for 'hold' extra cycles, then drop enable for two cycles.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv, input logic [3:0] top,
                        input int hold, input string name);
    logic [15:0] res;
    logic        err;
    int          n;
    int          lat [3];
    int          cyc;
    model(ta, tbv, top, res, err, n);
    lat = '{0, 0, 0};
    cyc = 0;
    @(negedge clk);
    a = ta; b = tbv; op = top; en = 1'b1;
    while (cyc < 60 && (lat[0] == 0 || lat[1] == 0 || lat[2] == 0)) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check($sformatf("%s busy after start", name), 32'(o_busy), 32'h7);
        a = 16'($urandom); b = 16'($urandom); op = 4'($urandom);
      end
      for (int i = 0; i < 3; i++) begin
        if (o_valid[i] && lat[i] == 0) begin
          lat[i] = cyc;
          check($sformatf("%s r%0d busy at valid", name, radix_of[i]), 32'(o_busy[i]), 32'd0);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s r%0d latency", name, radix_of[i]), 32'(lat[i]),
            32'(1 + n + ((radix_of[i] == 2) ? 0 : 5)));
      check($sformatf("%s r%0d result", name, radix_of[i]), 32'(o_res[i]), 32'(res));
      check($sformatf("%s r%0d digits", name, radix_of[i]), 32'(o_dig[i]),
            32'(model_digits(res, radix_of[i])));
      check($sformatf("%s r%0d error", name, radix_of[i]), 32'(o_err[i]), 32'(err));
      prev_res[i] = res;
      prev_dig[i] = model_digits(res, radix_of[i]);
    end
    repeat (hold) @(negedge clk);
    if (hold > 0) begin
      check($sformatf("%s held valid", name), 32'(o_valid), 32'h7);
      check($sformatf("%s held busy", name), 32'(o_busy), 32'd0);
      check($sformatf("%s held result", name), 32'(o_res[0]), 32'(res));
    end
    en = 1'b0;
    @(negedge clk);
    check_idle_outputs({name, " drop"});
    check($sformatf("%s error kept", name), 32'(o_err), err ? 32'h7 : 32'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [15:0] ra, rb;
    int          seen;
    reset = 1'b1; en = 1'b0; a = 16'd0; b = 16'd0; op = 4'd0;
    for (int i = 0; i < 3; i++) begin
      prev_res[i] = 16'd0;
      prev_dig[i] = 20'd0;
    end
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check("reset error", 32'(o_err), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(16'd144,  16'd72, 4'd0, 0, "add");
    run_op(16'd12,   16'd12, 4'd2, 2, "mul");
    run_op(16'd144,  16'd12, 4'd3, 0, "div");
    run_op(16'd5,    16'd0,  4'd3, 1, "div0");
    run_op(16'd100,  16'd2,  4'd7, 0, "shl2");
    run_op(16'd1000, 16'd3,  4'd8, 0, "shr3");
    run_op(16'd100,  16'd0,  4'd7, 0, "shl0");
    run_op(16'd7,    16'd9,  4'hF, 0, "illegal");
    run_op(16'd5,    16'd7,  4'd1, 0, "sub_wrap");
    run_op(16'hF0F0, 16'h3C3C, 4'd4, 0, "and");
    run_op(16'hF0F0, 16'h3C3C, 4'd5, 0, "or");
    run_op(16'hF0F0, 16'h3C3C, 4'd6, 0, "xor");
    run_op(16'hFFFF, 16'hFFFF, 4'd2, 0, "mul_max");
    run_op(16'hFFFF, 16'd1,  4'd3, 0, "div_max");
    run_op(16'h8001, 16'd15, 4'd7, 0, "shl15");
    run_op(16'h1234, 16'd16, 4'd8, 0, "shr16");
    run_op(16'h1234, 16'd20, 4'd7, 0, "shl20");

    // Abort: MUL dropped after five cycles must never produce a valid.
    @(negedge clk);
    a = 16'd12; b = 16'd12; op = 4'd2; en = 1'b1;
    repeat (5) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort");
    check("abort error cleared", 32'(o_err), 32'd0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_valid != 3'd0) seen = 1;
    end
    check("abort no late valid", 32'(seen), 32'd0);

    // Reset in the middle of a DIV clears every output on the next edge.
    run_op(16'd9, 16'd0, 4'd3, 0, "pre_reset");
    @(negedge clk);
    a = 16'd144; b = 16'd12; op = 4'd3; en = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      prev_res[i] = 16'd0;
      prev_dig[i] = 20'd0;
    end
    check_idle_outputs("mid_reset");
    check("mid_reset error", 32'(o_err), 32'd0);
    reset = 1'b0; en = 1'b0;
    @(negedge clk);

    // Randomized requests.
    for (int k = 0; k < 30; k++) begin
      rop = 4'($urandom_range(0, 9));
      if (rop == 4'd9) rop = 4'($urandom_range(9, 15));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (rop == 4'd7 || rop == 4'd8) rb = 16'($urandom_range(0, 20));
      if (rop == 4'd3 && ($urandom_range(0, 5) == 0)) rb = 16'd0;
      run_op(ra, rb, rop, int'($urandom_range(0, 2)), $sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/radix_alu_responder.md
Name: radix_alu_responder

Overview:
Responder end of the benchmark compute handshake: one instance per condition (base2, base10, base12), driven by the benchmark sequencer's operand_a/operand_b/operation/compute_enable and returning result_valid. Executes the nine-op ALU set with multi-cycle iterative MUL/DIV/shift. When RADIX is not 2, it then repacks the binary result into radix digits. The measured cycle cost therefore depends on both the op and the radix.

Parameters:
RADIX, 2, output digit radix; legal values 2, 10, 12. Any other value is treated as 2.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
compute_enable  in  1  request level from initiator; held high until result_valid is seen
operand_a  in  16  operand A; sampled at start only
operand_b  in  16  operand B / shift amount; sampled at start only
operation  in  4  0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 SHL, 8 SHR
result  out  16  binary result
result_digits  out  20  five 4-bit digits, LS digit in [3:0]; for RADIX=2 equals {4'h0, result}
result_valid  out  1  response valid, level
error  out  1  div-by-zero or illegal opcode for the current result
busy  out  1  high in EXEC/CONVERT

Behaviour:
- Reset values:
  - result = 0, result_digits = 0, result_valid = 0, error = 0, busy = 0.
  - State = IDLE; internal counters, accumulators and latched operands = 0.
  - Reset mid-operation aborts with no result_valid.
- States: IDLE, EXEC, CONVERT, VALID.
- IDLE:
  - Edge with compute_enable=1: latch operands and opcode, clear error, busy<=1, go to EXEC.
  - Otherwise stay.
- EXEC runs for N cycles:
  - ADD, SUB, AND, OR, XOR, illegal opcode: N=1. ADD/SUB wrap mod 2^16.
  - Illegal opcode: result 0, error=1.
  - MUL: N=16, shift-add, one multiplier bit per cycle; result = low 16 bits of the product.
  - DIV: N=16, restoring, one quotient bit per cycle; result = quotient.
  - Divisor 0: N=1, result 16'hFFFF, error=1.
  - SHL/SHR: logical, one bit position per cycle; N = max(1, b[3:0]).
  - SHL/SHR with b>=16: N=1, result 0.
- After EXEC: go to CONVERT if RADIX is 10 or 12, else go to VALID with result_valid<=1.
- CONVERT: C=5 cycles, one digit per cycle.
  - Each cycle: digit = r mod RADIX, then r = r / RADIX, by constant.
  - Digits fill [3:0] first through [19:16].
  - Max 65535 fits in 5 digits for both radices.
  - Then go to VALID with result_valid<=1.
- Latency: result_valid first high after N+C edges following the sampling edge (C=0 when RADIX=2).
- busy:
  - Drops on the same edge that result_valid rises.
  - Is high exactly for the N+C cycles between the start edge and result_valid rising.
- VALID:
  - result, result_digits and error are held stable.
  - result_valid stays 1 while compute_enable=1.
  - Edge with compute_enable=0: result_valid<=0, go to IDLE; outputs keep their last values.
- Back-to-back requests:
  - A new start requires compute_enable sampled low at least once after valid.
  - A level held high across VALID does not retrigger.
- Abort: compute_enable=0 sampled in EXEC or CONVERT → go to IDLE, busy<=0, result_valid never asserted; result and result_digits keep their previous values.
- Operand or opcode changes while busy are ignored.

Test Plan:
- RADIX=2, ADD 144+72 → result=216, result_digits=0x000D8, result_valid high 1 edge after start; drop enable → IDLE next edge.
- RADIX=10, ADD 144+72 → result_digits=0x00216, valid after 6 edges. RADIX=12, same request → result_digits=0x00160.
- RADIX=2:
  - MUL 12×12 → 144 at 16 edges.
  - DIV 144/12 → 12 at 16 edges.
  - DIV 5/0 → 0xFFFF, error=1 at 1 edge.
- SHL 100,b=2 → 400 at 2 edges; SHR 1000,b=3 → 125 at 3 edges; SHL b=0 → 100 at 1 edge; opcode 4'hF → 0, error=1.
- Abort: MUL started, compute_enable dropped after 5 cycles → no valid, busy=0, IDLE. Reset asserted mid-DIV → all outputs zero next edge.
- Back-to-back sequencer pattern (valid, enable low 2 cycles, enable high): no retrigger while enable is held high in VALID; second op completes with correct latency. Run all nine benchmark cases and check results and per-op latencies.
